control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 90 +++++++++
 1 files changed

// File: rtl/control_unit.sv
// control_unit: two-cycle FETCH/EXEC sequencer for a tiny accumulator machine.
// Ports:
//   i_clock, i_reset (sync, active-high), i_start (level, honoured in IDLE/HALT)
//   i_Instruction  program word at o_PC, captured into IR at the end of FETCH
//   o_PC           program counter / program memory address
//   o_Operand      IR[10:0], immediate value or data memory address
//   o_SelA, o_SelB, o_WrAcc, o_Op, o_WrRam, o_RdRam  datapath controls, live in EXEC only
//   o_busy, o_halted, o_illegal  status; o_retired  saturating retired-instruction count
module control_unit #(
    parameter int NBITS_OPC = 5,
    parameter int NBITS_O   = 11,
    parameter int NBITS_D   = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NBITS_D-1:0] i_Instruction,
    output logic [NBITS_O-1:0] o_PC,
    output logic [NBITS_O-1:0] o_Operand,
    output logic [1:0]         o_SelA,
    output logic               o_SelB,
    output logic               o_WrAcc,
    output logic               o_Op,
    output logic               o_WrRam,
    output logic               o_RdRam,
    output logic               o_busy,
    output logic               o_halted,
    output logic               o_illegal,
    output logic [15:0]        o_retired
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
    localparam logic [NBITS_OPC-1:0] HLT  = NBITS_OPC'(0);
    localparam logic [NBITS_OPC-1:0] STO  = NBITS_OPC'(1);
    localparam logic [NBITS_OPC-1:0] LD   = NBITS_OPC'(2);
    localparam logic [NBITS_OPC-1:0] LDI  = NBITS_OPC'(3);
    localparam logic [NBITS_OPC-1:0] ADD  = NBITS_OPC'(4);
    localparam logic [NBITS_OPC-1:0] ADDI = NBITS_OPC'(5);
    localparam logic [NBITS_OPC-1:0] SUB  = NBITS_OPC'(6);
    localparam logic [NBITS_OPC-1:0] SUBI = NBITS_OPC'(7);
    state_t               state, next_state;
    logic [NBITS_D-1:0]   ir;
    logic [NBITS_OPC-1:0] opc;
    logic                 ex;
    assign opc       = ir[NBITS_D-1 -: NBITS_OPC];
    assign ex        = state == EXEC;
    assign o_Operand = ir[NBITS_O-1:0];
    assign o_busy    = state == FETCH || state == EXEC;
    assign o_halted  = state == HALT;
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state     <= IDLE;
            o_PC      <= '0;
            ir        <= '0;
            o_retired <= '0;
            o_illegal <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE, HALT: if (i_start) begin
                    o_PC      <= '0;
                    o_retired <= '0;
                    o_illegal <= 1'b0;
                end
                FETCH: ir <= i_Instruction;
                EXEC: begin
                    o_retired <= (o_retired == 16'hFFFF) ? o_retired : o_retired + 16'd1;
                    if (opc != HLT) o_PC <= o_PC + NBITS_O'(1);
                    if (opc > SUBI) o_illegal <= 1'b1;
                end
                default: ;
            endcase
        end
    end
    always_comb begin
        next_state = (state == FETCH) ? EXEC :
                     (state == EXEC)  ? ((opc == HLT) ? HALT : FETCH) :
                     i_start          ? FETCH : state;
    end
    // Undefined opcodes (above SUBI) fall through every term below and act as NOPs.
    always_comb begin
        o_WrRam = ex && opc == STO;
        o_RdRam = ex && (opc == LD || opc == ADD || opc == SUB);
        o_WrAcc = ex && opc >= LD && opc <= SUBI;
        o_SelA  = !ex        ? 2'b00 :
                  opc == LDI ? 2'b01 :
                  (opc >= ADD && opc <= SUBI) ? 2'b10 : 2'b00;
        o_SelB  = ex && (opc == ADDI || opc == SUBI);
        o_Op    = ex && (opc == SUB || opc == SUBI);
    end
endmodule
